// File: rtl/mutex_client.sv
// Requester-side client for the two-port mutex arbiter: acquires the lock for a
// job of len beats, strobes one beat per granted unstalled cycle, then releases.
module mutex_client #(
  parameter int LEN_W    = 8,
  parameter int WAIT_MAX = 64,
  parameter int GAP      = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             stall,
  input  logic             val,
  output logic             req,
  output logic             beat,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic [LEN_W-1:0] cnt,
  output logic [1:0]       dbg_state
);

  localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam int GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);
  localparam logic [GAP_W-1:0]  GAP_LIM  = GAP_W'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_REL} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WAIT_W-1:0]  r_wait;
  logic [GAP_W-1:0]   r_gap;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_req;
  logic               r_done;
  logic               r_abort;
  logic               w_beat;
  logic               w_load;
  logic               w_done;
  logic               w_abort;

  // req/val handshake: req is held while this client wants the lock; a beat
  // moves only in a cycle where the arbiter's val is high and the user is not
  // stalling. Dropping req is the release.
  assign w_beat = (r_state == S_HOLD) && val && !stall;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_load = 1'b1;
            w_next = S_REQ;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (val) begin
          w_next = S_HOLD;
        end else if ((WAIT_MAX != 0) && (r_wait == WAIT_LIM)) begin
          w_abort = 1'b1;
          w_next  = S_REL;
        end
      end
      S_HOLD: begin
        if (!val) begin
          w_abort = 1'b1;
          w_next  = S_REL;
        end else if (w_beat && (r_cnt == LEN_W'(1))) begin
          w_done = 1'b1;
          w_next = S_REL;
        end
      end
      S_REL: begin
        // Exits only after the grant has been seen low for GAP whole cycles.
        if (!val && (r_gap == GAP_LIM)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_gap   <= '0;
    end else begin
      r_req   <= (w_next == S_REQ) || (w_next == S_HOLD);
      r_done  <= w_done;
      r_abort <= w_abort;

      if (w_load)                    r_cnt <= len;
      else if (w_beat && r_cnt != '0) r_cnt <= r_cnt - LEN_W'(1);

      if (r_state == S_REQ) begin
        if (!val && (r_wait != WAIT_LIM)) r_wait <= r_wait + WAIT_W'(1);
      end else begin
        r_wait <= '0;
      end

      if ((r_state == S_REL) && !val) begin
        if (r_gap != GAP_LIM) r_gap <= r_gap + GAP_W'(1);
      end else begin
        r_gap <= '0;
      end
    end
  end

  assign req       = r_req;
  assign beat      = w_beat;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign abort     = r_abort;
  assign cnt       = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mutex_client.sv
// Bench for mutex_client: vector table, randomized jobs against a job-level
// model, directed corner sequences and two clients sharing a modelled mutex.
module tb_mutex_client;

  logic       clk;
  logic       arst;
  logic       start;
  logic [7:0] len;
  logic       stall;
  logic       val;
  logic       req, beat, busy, done, abort;
  logic [7:0] cnt;
  logic [1:0] dbg_state;

  logic       s0, s1, v0, v1;
  logic       r0, r1, b0, b1, bz0, bz1, d0, d1, a0, a1;
  logic [7:0] c0, c1;
  logic [1:0] st0, st1;
  logic [1:0] own;

  int n_pass  = 0;
  int n_total = 0;
  int t_beats, t_done, t_abort;
  logic [8:0] exp_q[$];

  typedef struct {
    int          len;
    int          delay;
    logic [31:0] smask;
    int          lose;
    logic        rel_start;
    int          e_beats;
    int          e_done;
    int          e_abort;
    int          e_cnt;
  } vec_t;
  vec_t vecs[7];

  mutex_client #(.LEN_W(8), .WAIT_MAX(8), .GAP(2)) u_dut (
    .clk(clk), .arst(arst), .start(start), .len(len), .stall(stall), .val(val),
    .req(req), .beat(beat), .busy(busy), .done(done), .abort(abort), .cnt(cnt),
    .dbg_state(dbg_state)
  );

  mutex_client #(.LEN_W(8), .WAIT_MAX(64), .GAP(2)) u_c0 (
    .clk(clk), .arst(arst), .start(s0), .len(8'd2), .stall(1'b0), .val(v0),
    .req(r0), .beat(b0), .busy(bz0), .done(d0), .abort(a0), .cnt(c0),
    .dbg_state(st0)
  );

  mutex_client #(.LEN_W(8), .WAIT_MAX(64), .GAP(2)) u_c1 (
    .clk(clk), .arst(arst), .start(s1), .len(8'd2), .stall(1'b0), .val(v1),
    .req(r1), .beat(b1), .busy(bz1), .done(d1), .abort(a1), .cnt(c1),
    .dbg_state(st1)
  );

  // Arbiter model: grant holds while its owner requests; on release the other
  // requester is granted at the same edge; port 0 wins a simultaneous request.
  always @(posedge clk or posedge arst) begin
    if (arst) own <= 2'b00;
    else if (own == 2'b00) own <= r0 ? 2'b01 : (r1 ? 2'b10 : 2'b00);
    else if (own[0] && !r0) own <= r1 ? 2'b10 : 2'b00;
    else if (own[1] && !r1) own <= r0 ? 2'b01 : 2'b00;
  end
  assign v0 = own[0];
  assign v1 = own[1];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One cycle: inputs applied mid-cycle, outputs settled 1ns later.
  task automatic cyc(input logic s, input logic [7:0] l, input logic v, input logic st);
    @(negedge clk);
    start = s;
    len   = l;
    val   = v;
    stall = st;
    #1;
    t_beats += int'(beat);
    t_done  += int'(done);
    t_abort += int'(abort);
  endtask

  task automatic run_job(input int l, input int delay, input logic [31:0] smask,
                         input int lose, input logic rel_start,
                         output int beats, output int dones, output int aborts,
                         output int fcnt);
    int   b;
    int   loss_j;
    int   j;
    logic stl;
    logic [8:0] e;
    // model: expected {beat, cnt} for every cycle spent holding the grant
    exp_q.delete();
    b      = 0;
    loss_j = -1;
    j      = 0;
    forever begin
      if (lose < l && b == lose) begin
        exp_q.push_back({1'b0, 8'(l - b)});
        loss_j = j;
        break;
      end
      stl = (j < 32) ? smask[j[4:0]] : 1'b0;
      exp_q.push_back({!stl, 8'(l - b)});
      if (!stl) b++;
      if (b == l) break;
      j++;
    end
    t_beats = 0; t_done = 0; t_abort = 0;
    cyc(1'b1, 8'(l), 1'b0, 1'b0);
    for (int i = 0; i <= delay; i++) begin
      cyc(1'b0, 8'd0, (i == delay), 1'b0);
      if (i == 0) begin
        chk("req_after_start", req, 1);
        chk("busy_after_start", busy, 1);
      end
    end
    j = 0;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      stl = (j < 32) ? smask[j[4:0]] : 1'b0;
      cyc(1'b0, 8'd0, (j != loss_j), stl);
      chk("hold_beat", beat, e[8]);
      chk("hold_cnt", cnt, e[7:0]);
      j++;
    end
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    chk("end_done", done, (b == l));
    chk("end_abort", abort, (b != l));
    chk("end_req_low", req, 0);
    fcnt = cnt;
    cyc(rel_start, 8'd5, 1'b0, 1'b0);
    chk("rel_busy_1", busy, 1);
    chk("pulse_once", done | abort, 0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    chk("rel_busy_2", busy, 1);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    chk("back_idle", busy, 0);
    chk("idle_req", req, 0);
    if (rel_start) begin
      cyc(1'b0, 8'd0, 1'b0, 1'b0);
      chk("rel_start_ignored", busy, 0);
    end
    beats  = t_beats;
    dones  = t_done;
    aborts = t_abort;
  endtask

  initial begin
    int beats, dones, aborts, fcnt;
    int l, d, lo;
    logic [31:0] m;
    int both, extra, nb0, nb1, nd0, nd1, dn0, fb1, who;

    vecs[0] = '{4,   2, 32'h0,        99,  1'b0, 4,   1, 0, 0};
    vecs[1] = '{3,   0, 32'b010,      99,  1'b0, 3,   1, 0, 0};
    vecs[2] = '{5,   1, 32'h0,        2,   1'b0, 2,   0, 1, 3};
    vecs[3] = '{1,   0, 32'h0,        99,  1'b1, 1,   1, 0, 0};
    vecs[4] = '{6,   3, 32'b101101,   99,  1'b0, 6,   1, 0, 0};
    vecs[5] = '{4,   0, 32'h0,        0,   1'b0, 0,   0, 1, 4};
    vecs[6] = '{255, 0, 32'h0,        999, 1'b0, 255, 1, 0, 0};

    arst = 1'b1; start = 1'b0; len = 8'd0; stall = 1'b0; val = 1'b0;
    s0 = 1'b0; s1 = 1'b0;
    t_beats = 0; t_done = 0; t_abort = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_beat", beat, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    arst = 1'b0;

    // vector table
    for (int k = 0; k < 7; k++) begin
      run_job(vecs[k].len, vecs[k].delay, vecs[k].smask, vecs[k].lose,
              vecs[k].rel_start, beats, dones, aborts, fcnt);
      chk("vec_beats", beats, vecs[k].e_beats);
      chk("vec_done", dones, vecs[k].e_done);
      chk("vec_abort", aborts, vecs[k].e_abort);
      chk("vec_cnt", fcnt, vecs[k].e_cnt);
    end

    // randomized jobs
    for (int k = 0; k < 25; k++) begin
      l  = $urandom_range(1, 12);
      d  = $urandom_range(0, 7);
      m  = $urandom;
      lo = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, l - 1)) : l;
      run_job(l, d, m, lo, 1'b0, beats, dones, aborts, fcnt);
      chk("rnd_beats", beats, (lo < l) ? lo : l);
      chk("rnd_done", dones, (lo < l) ? 0 : 1);
      chk("rnd_abort", aborts, (lo < l) ? 1 : 0);
      chk("rnd_cnt", fcnt, (lo < l) ? l - lo : 0);
    end

    // grant never arrives: timeout abort
    t_beats = 0; t_done = 0; t_abort = 0;
    cyc(1'b1, 8'd3, 1'b0, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      cyc(1'b0, 8'd0, 1'b0, 1'b0);
      if (i == 9) begin
        chk("to_early_abort", t_abort, 0);
        chk("to_req_held", req, 1);
      end
      if (i == 10) begin
        chk("to_abort", abort, 1);
        chk("to_req_low", req, 0);
      end
      if (i == 12) chk("to_gap_busy", busy, 1);
      if (i == 13) chk("to_idle", busy, 0);
    end
    chk("to_no_done", t_done, 0);

    // zero-length job
    t_done = 0;
    cyc(1'b1, 8'd0, 1'b0, 1'b0);
    chk("len0_no_req", req, 0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_req", req, 0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    chk("len0_done_once", t_done, 1);

    // stale grant while idle
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);
    chk("stale_busy", busy, 0);
    chk("stale_req", req, 0);
    chk("stale_beat", beat, 0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);

    // asynchronous reset during HOLD
    cyc(1'b1, 8'd10, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    chk("pre_rst_beat", beat, 1);
    #2 arst = 1'b1;
    #1;
    chk("arst_req", req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_beat", beat, 0);
    chk("arst_cnt", cnt, 0);
    @(negedge clk);
    arst = 1'b0;
    t_done = 0; t_abort = 0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b0, 1'b0);
    chk("arst_no_pulse", t_done + t_abort, 0);

    // two clients on one arbiter
    exp_q.delete();
    exp_q.push_back(9'd0); exp_q.push_back(9'd0);
    exp_q.push_back(9'd1); exp_q.push_back(9'd1);
    both = 0; extra = 0; nb0 = 0; nb1 = 0; nd0 = 0; nd1 = 0; dn0 = -1; fb1 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      s0 = (i == 0);
      s1 = (i == 0);
      #1;
      if (b0 && b1) both++;
      if (b0 || b1) begin
        who = b0 ? 0 : 1;
        if (exp_q.size() > 0) chk("mx_order", who, exp_q.pop_front());
        else extra++;
      end
      nb0 += int'(b0);
      nb1 += int'(b1);
      nd0 += int'(d0);
      nd1 += int'(d1);
      if (d0 && dn0 < 0) dn0 = i;
      if (b1 && fb1 < 0) fb1 = i;
    end
    chk("mx_no_overlap", both, 0);
    chk("mx_extra_beats", extra, 0);
    chk("mx_all_beats", exp_q.size(), 0);
    chk("mx_beats0", nb0, 2);
    chk("mx_beats1", nb1, 2);
    chk("mx_done0", nd0, 1);
    chk("mx_done1", nd1, 1);
    chk("mx_serial_gap", (dn0 >= 0 && fb1 >= 0 && fb1 - dn0 >= 2), 1);
    chk("mx_no_abort", int'(a0) + int'(a1), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
